smol_multi: RTL and testbench

SMOL_MULTI -- requirements
Module: smol_multi

---
 rtl/smol_multi.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_smol_multi.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smol_multi.sv
// smol_multi: SPI slave with two personalities selected by MODE.
//   MODE = 0 : 4x4 unsigned multiplier. The slave takes A and B serially and
//              shifts out the 8-bit product P = A*B, MSB first.
//   MODE = 1 : 128 x 8 memory. Each access starts with an 8-bit command
//              (bit 7 = read, bits 6:0 = address), followed by a data phase.
// SCLK, CS and MOSI are asynchronous to CLK. They are synchronized and
// edge-detected in the CLK domain, so every SPI event becomes a one-CLK pulse.
module smol_multi #(
    parameter int MODE = 0
) (
    input  logic CLK,
    input  logic reset,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO
);

    // ------------------------------------------------------------------
    // Shared front end: synchronizers and SCLK edge detection
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_cs_s1, r_cs_s2;
    logic r_mosi_s1, r_mosi_s2;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_act;

    // Two-flop synchronizers, plus a history flop on SCLK for edge pulses.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the pre-edge value of the others, as real hardware does.
        if (reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= CS;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    // The multiplier uses an active-high select. The memory uses an
    // active-low select.
    assign w_cs_act    = (MODE == 0) ? r_cs_s2 : ~r_cs_s2;

    generate
        if (MODE == 0) begin : g_mult
            // ----------------------------------------------------------
            // Multiplier slave
            // ----------------------------------------------------------
            typedef enum logic [2:0] {
                IDLE, START, LOAD_A, LOAD_B, CALC, SHIFT_OUT, DONE
            } state_t;

            state_t     r_state;
            state_t     w_next;
            logic [3:0] r_a;
            logic [3:0] r_b;
            logic [3:0] r_cnt;
            logic [7:0] r_shift;
            logic       r_miso;
            logic       w_cnt_last;

            // Each of the load and calc phases spans four SCLK rises.
            assign w_cnt_last = (r_cnt == 4'd3);

            // State register.
            always_ff @(posedge CLK) begin
                if (reset) r_state <= IDLE;
                else       r_state <= w_next;
            end

            // Next-state logic. Deselect always wins and returns the FSM to IDLE.
            always_comb begin
                // NOTE: default first, so no path leaves w_next unassigned and
                // no latch is inferred.
                w_next = r_state;
                if (!w_cs_act) begin
                    w_next = IDLE;
                end else begin
                    case (r_state)
                        IDLE:      if (w_sclk_rise)                w_next = START;
                        START:     if (w_sclk_rise)                w_next = LOAD_A;
                        LOAD_A:    if (w_sclk_rise && w_cnt_last)  w_next = LOAD_B;
                        LOAD_B:    if (w_sclk_rise && w_cnt_last)  w_next = CALC;
                        CALC:      if (w_sclk_rise && w_cnt_last)  w_next = SHIFT_OUT;
                        SHIFT_OUT: if (w_sclk_fall && r_cnt == 4'd8) w_next = DONE;
                        DONE:      w_next = DONE;
                        default:   w_next = IDLE;
                    endcase
                end
            end

            // Datapath: operand shift-in, product capture and serial shift-out.
            always_ff @(posedge CLK) begin
                if (reset || !w_cs_act) begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_cnt   <= '0;
                    r_shift <= '0;
                    r_miso  <= 1'b0;
                end else begin
                    case (r_state)
                        START: begin
                            // This rise carries the first A bit. The rise that
                            // entered START carried a MOSI bit that is ignored.
                            if (w_sclk_rise) begin
                                r_a   <= {r_a[2:0], r_mosi_s2};
                                r_cnt <= 4'd1;
                            end
                        end
                        LOAD_A: begin
                            if (w_sclk_rise) begin
                                r_a   <= {r_a[2:0], r_mosi_s2};
                                r_cnt <= w_cnt_last ? 4'd0 : r_cnt + 4'd1;
                            end
                        end
                        LOAD_B: begin
                            if (w_sclk_rise) begin
                                r_b   <= {r_b[2:0], r_mosi_s2};
                                r_cnt <= w_cnt_last ? 4'd0 : r_cnt + 4'd1;
                            end
                        end
                        CALC: begin
                            // The operands are stable here, so the product is
                            // simply recaptured on every CLK.
                            r_shift <= {4'b0000, r_a} * {4'b0000, r_b};
                            if (w_sclk_rise) begin
                                r_cnt <= w_cnt_last ? 4'd0 : r_cnt + 4'd1;
                            end
                        end
                        SHIFT_OUT: begin
                            if (w_sclk_fall) begin
                                if (r_cnt == 4'd8) begin
                                    r_miso <= 1'b0;
                                    r_cnt  <= '0;
                                end else begin
                                    r_miso  <= r_shift[7];
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    r_cnt   <= r_cnt + 4'd1;
                                end
                            end
                        end
                        default: r_miso <= 1'b0;
                    endcase
                end
            end

            // Output logic: MISO carries data only while shifting out.
            always_comb begin
                MISO = 1'b0;
                if (r_state == SHIFT_OUT) MISO = r_miso;
            end

        end else begin : g_mem
            // ----------------------------------------------------------
            // Memory slave
            // ----------------------------------------------------------
            typedef enum logic [2:0] {
                CMD, WGAP, WDATA, WEND, RWAIT, RDATA
            } state_t;

            state_t     r_state;
            state_t     w_next;
            logic [7:0] r_mem [128];
            logic [7:0] r_cmd;
            logic [6:0] r_addr;
            logic [7:0] r_data;
            logic       r_we;
            logic [3:0] r_cnt;
            logic [7:0] r_shift;
            logic       r_miso;
            logic [7:0] w_rd_byte;

            assign w_rd_byte = r_mem[r_addr];

            // State register.
            always_ff @(posedge CLK) begin
                if (reset) r_state <= CMD;
                else       r_state <= w_next;
            end

            // Next-state logic. Deselect returns the FSM to command reception.
            // r_cmd[6] holds the R/W bit when the eighth command bit arrives.
            always_comb begin
                w_next = r_state;
                if (!w_cs_act) begin
                    w_next = CMD;
                end else begin
                    case (r_state)
                        CMD:     if (w_sclk_rise && r_cnt == 4'd7)
                                     w_next = r_cmd[6] ? RWAIT : WGAP;
                        WGAP:    if (w_sclk_rise)                  w_next = WDATA;
                        WDATA:   if (w_sclk_rise && r_cnt == 4'd7) w_next = WEND;
                        WEND:    if (w_sclk_rise)                  w_next = CMD;
                        RWAIT:   if (w_sclk_fall && r_cnt == 4'd3) w_next = RDATA;
                        RDATA:   if (w_sclk_fall && r_cnt == 4'd8) w_next = CMD;
                        default: w_next = CMD;
                    endcase
                end
            end

            // Datapath: command/data shift-in, memory write, read shift-out.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    // NOTE: clearing the array makes it a register file rather
                    // than a RAM macro. This is intentional, because unwritten
                    // locations must read back as zero after reset.
                    for (int i = 0; i < 128; i++) r_mem[i] <= '0;
                    r_cmd   <= '0;
                    r_addr  <= '0;
                    r_data  <= '0;
                    r_we    <= 1'b0;
                    r_cnt   <= '0;
                    r_shift <= '0;
                    r_miso  <= 1'b0;
                end else begin
                    // The write strobe lasts one CLK, on the CLK after the last
                    // data bit arrives.
                    r_we <= 1'b0;
                    if (r_we) r_mem[r_addr] <= r_data;

                    if (!w_cs_act) begin
                        r_cmd  <= '0;
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                    end else begin
                        case (r_state)
                            CMD: begin
                                if (w_sclk_rise) begin
                                    r_cmd <= {r_cmd[6:0], r_mosi_s2};
                                    if (r_cnt == 4'd7) begin
                                        r_addr <= {r_cmd[5:0], r_mosi_s2};
                                        r_cnt  <= '0;
                                    end else begin
                                        r_cnt <= r_cnt + 4'd1;
                                    end
                                end
                            end
                            WDATA: begin
                                if (w_sclk_rise) begin
                                    r_data <= {r_data[6:0], r_mosi_s2};
                                    if (r_cnt == 4'd7) begin
                                        r_we  <= 1'b1;
                                        r_cnt <= '0;
                                    end else begin
                                        r_cnt <= r_cnt + 4'd1;
                                    end
                                end
                            end
                            RWAIT: begin
                                // Bit 7 goes out on the fourth fall after the
                                // last command rise.
                                if (w_sclk_fall) begin
                                    if (r_cnt == 4'd3) begin
                                        r_miso  <= w_rd_byte[7];
                                        r_shift <= {w_rd_byte[6:0], 1'b0};
                                        r_cnt   <= 4'd1;
                                    end else begin
                                        r_cnt <= r_cnt + 4'd1;
                                    end
                                end
                            end
                            RDATA: begin
                                if (w_sclk_fall) begin
                                    if (r_cnt == 4'd8) begin
                                        r_miso <= 1'b0;
                                        r_cnt  <= '0;
                                    end else begin
                                        r_miso  <= r_shift[7];
                                        r_shift <= {r_shift[6:0], 1'b0};
                                        r_cnt   <= r_cnt + 4'd1;
                                    end
                                end
                            end
                            default: r_miso <= 1'b0;
                        endcase
                    end
                end
            end

            // Output logic: MISO carries data only during the read data phase.
            always_comb begin
                MISO = 1'b0;
                if (r_state == RDATA) MISO = r_miso;
            end
        end
    endgenerate

endmodule

// File: tb/tb_smol_multi.sv
// Directed bench for smol_multi. One instance of each MODE is driven with
// hand-computed SPI transactions. SCLK half-periods are 6 CLK long.
module tb_smol_multi;

    logic clk = 1'b0;
    logic rst;
    logic sclk0, cs0, mosi0, miso0;
    logic sclk1, cs1, mosi1, miso1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    smol_multi #(.MODE(0)) dut0 (
        .CLK(clk), .reset(rst), .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0)
    );

    smol_multi #(.MODE(1)) dut1 (
        .CLK(clk), .reset(rst), .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // One SCLK period. MISO is sampled just before the rise.
    task automatic spi0_bit(input logic m, output logic s);
        mosi0 = m;
        wait_clk(6);
        s = miso0;
        sclk0 = 1'b1;
        wait_clk(6);
        sclk0 = 1'b0;
    endtask

    task automatic spi1_bit(input logic m, output logic s);
        mosi1 = m;
        wait_clk(6);
        s = miso1;
        sclk1 = 1'b1;
        wait_clk(6);
        sclk1 = 1'b0;
    endtask

    // Full multiplier transaction: rise 1 (ignored), A, B, 4 calc rises, 8 product rises.
    task automatic mult_run(input logic [3:0] a, input logic [3:0] b,
                            output logic [7:0] p, output logic tail);
        logic s, t0;
        cs0 = 1'b1;
        wait_clk(4);
        spi0_bit(1'b1, s);
        for (int i = 3; i >= 0; i--) spi0_bit(a[i], s);
        for (int i = 3; i >= 0; i--) spi0_bit(b[i], s);
        for (int i = 0; i < 4; i++)  spi0_bit(1'b1, s);
        for (int i = 7; i >= 0; i--) begin
            spi0_bit(1'b0, s);
            p[i] = s;
        end
        wait_clk(6);
        t0 = miso0;
        spi0_bit(1'b1, s);   // extra rise while in DONE must not restart
        wait_clk(6);
        tail = t0 | miso0;
        cs0 = 1'b0;
        wait_clk(6);
    endtask

    task automatic mem_write(input logic [6:0] addr, input logic [7:0] data);
        logic s;
        spi1_bit(1'b0, s);
        for (int i = 6; i >= 0; i--) spi1_bit(addr[i], s);
        spi1_bit(1'b1, s);
        for (int i = 7; i >= 0; i--) spi1_bit(data[i], s);
        spi1_bit(1'b1, s);
    endtask

    task automatic mem_read(input logic [6:0] addr, output logic [7:0] data,
                            output logic tail);
        logic s;
        spi1_bit(1'b1, s);
        for (int i = 6; i >= 0; i--) spi1_bit(addr[i], s);
        for (int i = 0; i < 3; i++)  spi1_bit(1'b1, s);
        for (int i = 7; i >= 0; i--) begin
            spi1_bit(1'b0, s);
            data[i] = s;
        end
        wait_clk(6);
        tail = miso1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (miso0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso0: got %b expected 0", miso0);
        end
        checks++;
        if (miso1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso1: got %b expected 0", miso1);
        end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mult();
        logic [3:0] va [5];
        logic [3:0] vb [5];
        logic [7:0] vp [5];
        logic [7:0] p;
        logic       tail;
        va = '{4'd1, 4'd15, 4'd0,  4'd2, 4'd9};
        vb = '{4'd6, 4'd15, 4'd11, 4'd3, 4'd7};
        vp = '{8'h06, 8'hE1, 8'h00, 8'h06, 8'h3F};
        for (int k = 0; k < 5; k++) begin
            mult_run(va[k], vb[k], p, tail);
            checks++;
            if (p !== vp[k]) begin
                errors++;
                $display("FAIL mult_product[%0d]: got %h expected %h", k, p, vp[k]);
            end
            checks++;
            if (tail !== 1'b0) begin
                errors++;
                $display("FAIL mult_done_miso[%0d]: got %b expected 0", k, tail);
            end
        end
    endtask

    task automatic test_mult_abort();
        logic s, tail;
        logic [7:0] p;
        // Drop CS after rise 6.
        cs0 = 1'b1;
        wait_clk(4);
        spi0_bit(1'b1, s);
        spi0_bit(1'b0, s); spi0_bit(1'b0, s); spi0_bit(1'b1, s); spi0_bit(1'b0, s);
        spi0_bit(1'b1, s);
        cs0 = 1'b0;
        wait_clk(4);
        checks++;
        if (miso0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_miso: got %b expected 0", miso0);
        end
        mult_run(4'd2, 4'd3, p, tail);
        checks++;
        if (p !== 8'h06) begin
            errors++;
            $display("FAIL abort_next_product: got %h expected 06", p);
        end
        // Deselect while a 1 is on MISO, so MISO must clear within 3 CLK.
        cs0 = 1'b1;
        wait_clk(4);
        spi0_bit(1'b1, s);
        for (int i = 0; i < 8; i++)  spi0_bit(1'b1, s);
        for (int i = 0; i < 5; i++)  spi0_bit(1'b0, s);   // rises 10-14
        wait_clk(6);
        checks++;
        if (miso0 !== 1'b1) begin
            errors++;
            $display("FAIL deselect_pre_miso: got %b expected 1", miso0);
        end
        cs0 = 1'b0;
        wait_clk(3);
        checks++;
        if (miso0 !== 1'b0) begin
            errors++;
            $display("FAIL deselect_miso: got %b expected 0", miso0);
        end
        wait_clk(4);
    endtask

    task automatic test_mult_reset();
        logic s, tail;
        logic [7:0] p;
        cs0 = 1'b1;
        wait_clk(4);
        spi0_bit(1'b1, s);
        for (int i = 0; i < 8; i++)  spi0_bit(1'b1, s);
        for (int i = 0; i < 5; i++)  spi0_bit(1'b0, s);   // rise 14 samples P7
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL rst_shift_p7: got %b expected 1", s);
        end
        wait_clk(6);
        checks++;
        if (miso0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_shift_p6: got %b expected 1", miso0);
        end
        pulse_reset();
        checks++;
        if (miso0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_shift_miso: got %b expected 0", miso0);
        end
        cs0 = 1'b0;
        wait_clk(6);
        mult_run(4'd15, 4'd15, p, tail);
        checks++;
        if (p !== 8'hE1) begin
            errors++;
            $display("FAIL rst_next_product: got %h expected e1", p);
        end
    endtask

    task automatic test_mem();
        logic [7:0] d;
        logic       tail;
        cs1 = 1'b0;
        wait_clk(4);
        mem_read(7'h03, d, tail);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL mem_read_unwritten: got %h expected 00", d);
        end
        checks++;
        if (tail !== 1'b0) begin
            errors++;
            $display("FAIL mem_read_tail: got %b expected 0", tail);
        end
        mem_write(7'h55, 8'h06);
        mem_read(7'h55, d, tail);
        checks++;
        if (d !== 8'h06) begin
            errors++;
            $display("FAIL mem_raw_55: got %h expected 06", d);
        end
        mem_write(7'h03, 8'hA5);
        mem_read(7'h03, d, tail);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL mem_raw_03: got %h expected a5", d);
        end
        mem_read(7'h7F, d, tail);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL mem_read_7f: got %h expected 00", d);
        end
        mem_read(7'h55, d, tail);
        checks++;
        if (d !== 8'h06) begin
            errors++;
            $display("FAIL mem_reread_55: got %h expected 06", d);
        end
        cs1 = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_mem_reset();
        logic [7:0] d;
        logic       s, tail;
        cs1 = 1'b0;
        wait_clk(4);
        // Write 0xFF to 0x10, interrupted by reset after four data bits.
        spi1_bit(1'b0, s);
        for (int i = 6; i >= 0; i--) spi1_bit(((7'h10 >> i) & 7'h01) != 7'h00, s);
        spi1_bit(1'b1, s);
        for (int i = 0; i < 4; i++) spi1_bit(1'b1, s);
        pulse_reset();
        checks++;
        if (miso1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_wdata_miso: got %b expected 0", miso1);
        end
        wait_clk(4);
        mem_read(7'h10, d, tail);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_no_write: got %h expected 00", d);
        end
        mem_read(7'h55, d, tail);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_mem_cleared: got %h expected 00", d);
        end
        mem_write(7'h10, 8'h3C);
        mem_read(7'h10, d, tail);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL rst_next_write: got %h expected 3c", d);
        end
        // Reset partway through a read, with a 1 on MISO.
        spi1_bit(1'b1, s);
        for (int i = 6; i >= 0; i--) spi1_bit(((7'h10 >> i) & 7'h01) != 7'h00, s);
        for (int i = 0; i < 3; i++) spi1_bit(1'b1, s);
        for (int i = 0; i < 3; i++) spi1_bit(1'b0, s);   // bits 7,6,5 = 0,0,1
        wait_clk(6);
        checks++;
        if (miso1 !== 1'b1) begin
            errors++;
            $display("FAIL rdata_bit4: got %b expected 1", miso1);
        end
        pulse_reset();
        checks++;
        if (miso1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_rdata_miso: got %b expected 0", miso1);
        end
        wait_clk(4);
        mem_read(7'h10, d, tail);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_rdata_cleared: got %h expected 00", d);
        end
        cs1 = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        rst   = 1'b1;
        sclk0 = 1'b0; cs0 = 1'b0; mosi0 = 1'b0;
        sclk1 = 1'b0; cs1 = 1'b1; mosi1 = 1'b0;
        test_reset();
        test_mult();
        test_mult_abort();
        test_mult_reset();
        test_mem();
        test_mem_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
